large_acc_to_float: RTL and testbench
=====================================

// Module: large_acc_to_float
// PURPOSE
//  Exact float32 accumulator back end. Consumes the 279-bit two's-complement fixed-point terms
//  from the float-to-large-integer stage. Term LSB weight is 2^-150.
//  Sums a batch of terms without rounding in a wide accumulator, then normalises the total.
//  Returns one float32 per batch, truncated toward zero. Sits between the expander and the
//  Versat unit's output FIFO.
// PARAMETERS
//  IN_W       279  input term width, signed two's complement, sign-extended to ACC_W
//  ACC_W      300  accumulator width; exact for up to 2^(ACC_W-280) terms per batch, then wraps
//  SCAN_STEP  8    bits skipped per cycle in the coarse leading-zero scan (1..16)
// PORTS
//  clk_i        in   1      clock, all logic on rising edge
//  rst_n_i      in   1      reset, synchronous, active-low
//  in_valid_i   in   1      term valid
//  in_ready_o   out  1      term accepted when in_valid_i & in_ready_o
//  in_data_i    in   IN_W   term; inf/NaN-derived terms unsupported (bit 278 reachable only by them)
//  in_last_i    in   1      qualifies the accepted term as the last of the batch
//  out_valid_o  out  1      result valid, held until accepted
//  out_ready_i  in   1      result consumed when out_valid_o & out_ready_i
//  out_data_o   out  32     float32 result
// BEHAVIOUR
//  Reset (rst_n_i=0 at an edge; wins over everything, including mid-batch or mid-scan):
//   state=ACCUM, acc=0, in_ready_o=1, out_valid_o=0, out_data_o=0.
//  FSM states:
//   ACCUM: in_ready_o=1.
//    - Each accepted beat: acc <= acc + sext(in_data_i), mod 2^ACC_W.
//    - Accepted beat with in_last_i=1: go to ABS.
//   ABS (1 cycle): in_ready_o=0.
//    - sgn <= acc[ACC_W-1]; mag <= |acc|; p <= ACC_W-1.
//    - acc==0: go to PACK with zero flag set; otherwise go to SCAN.
//   SCAN: each cycle, in priority order:
//    - mag[ACC_W-1]=1 or p==23: go to PACK.
//    - Top SCAN_STEP bits zero and p-SCAN_STEP>=23: mag<<=SCAN_STEP, p-=SCAN_STEP.
//    - Otherwise: mag<<=1, p-=1.
//   PACK (1 cycle): compute the word and register it into out_data_o; out_valid_o <= 1; go to OUT.
//    - zero: out_data_o = 0x00000000 (+0, never -0).
//    - p>=24 and p-23>=255: out_data_o = {sgn, 8'hFF, 23'h0} (±inf).
//    - p>=24 otherwise: out_data_o = {sgn, (p-23)[7:0], mag[ACC_W-2 -: 23]} (normal, truncated).
//    - p==23 with mag[ACC_W-1]=0 (below 2^23): out_data_o = {sgn, 8'h00, mag[ACC_W-1 -: 23]}
//      (= original |acc|[23:1], denormal, truncated).
//   OUT: out_valid_o=1; out_data_o stable; in_ready_o=0.
//    - On out_ready_i=1: out_valid_o <= 0, acc <= 0, go to ACCUM.
//    - in_ready_o rises the cycle after the output handshake.
//  Latency:
//   - ABS starts the cycle after the last beat.
//   - out_valid_o rises at most 3 + ceil((ACC_W-24)/SCAN_STEP) + SCAN_STEP cycles after the
//     last beat; the exact count is data-dependent.
//  Throughput: one term per cycle in ACCUM. No input accepted from last beat until the output
//   handshake; a single-beat batch (first beat carries in_last_i=1) is legal.
//  Outputs are registered; no combinational path from inputs to outputs except none.
// TESTING
//  1. Single beat, in_data_i=2^150 (1.0), last=1 -> out_data_o=0x3F800000; in_ready_o=0 until handshake.
//  2. Beats 2^150, -(2^150) (1.0 + -1.0) -> 0x00000000; result is +0, not -0.
//  3. Beats 3*2^149 (1.5), 9*2^148 (2.25), 1 (2^-150) -> 0x40700000 (3.75, tiny term truncated).
//  4. Four beats 0xFFFFFF<<254 (max finite) -> 0x7F800000; the same negated -> 0xFF800000.
//  5. Underflow path:
//     - single beat 6 -> 0x00000003
//     - single beat -6 -> 0x80000003
//     - single beat 1 -> 0x00000000
//  6. Handshake and reset:
//     - hold out_ready_i=0 for 5 cycles in OUT -> out_valid_o/out_data_o stable and in_ready_o=0;
//     - drive rst_n_i=0 mid-SCAN -> next cycle out_valid_o=0, in_ready_o=1;
//     - then one beat 2^150 -> 0x3F800000 (acc cleared by reset).

Source files
------------

// File: rtl/large_acc_to_float.sv
// Exact batch accumulator for 279-bit fixed-point terms (LSB weight 2^-150); emits one
// float32 per batch, truncated toward zero.
// Ports: clk_i, rst_n_i (sync, active-low); in_valid_i/in_ready_o/in_data_i/in_last_i term
// stream; out_valid_o/out_ready_i/out_data_o result stream.
module large_acc_to_float #(
    parameter int IN_W      = 279,
    parameter int ACC_W     = 300,
    parameter int SCAN_STEP = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [IN_W-1:0] in_data_i,
    input  logic            in_last_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_data_o
);

    localparam int PW = $clog2(ACC_W) + 1;

    typedef enum logic [2:0] {
        ST_ACCUM,
        ST_ABS,
        ST_SCAN,
        ST_PACK,
        ST_OUT
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   mag_q, mag_d;
    logic [PW-1:0]      p_q, p_d;
    logic               sgn_q, sgn_d;
    logic               zero_q, zero_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [ACC_W-1:0]   term_ext;
    logic [PW-1:0]      exp_w;

    assign term_ext = {{(ACC_W-IN_W){in_data_i[IN_W-1]}}, in_data_i};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mag_d       = mag_q;
        p_d         = p_q;
        sgn_d       = sgn_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        // p tracks the original bit position now sitting in mag[ACC_W-1];
        // that bit's biased float exponent is p-23.
        exp_w       = p_q - PW'(23);
        unique case (state_q)
            ST_ACCUM: begin
                if (in_valid_i && in_ready_q) begin
                    acc_d = acc_q + term_ext;
                    if (in_last_i) begin
                        state_d    = ST_ABS;
                        in_ready_d = 1'b0;
                    end
                end
            end
            ST_ABS: begin
                sgn_d  = acc_q[ACC_W-1];
                mag_d  = acc_q[ACC_W-1] ? (~acc_q + 1'b1) : acc_q;
                p_d    = PW'(ACC_W-1);
                zero_d = (acc_q == '0);
                state_d = (acc_q == '0) ? ST_PACK : ST_SCAN;
            end
            ST_SCAN: begin
                if (mag_q[ACC_W-1] || p_q == PW'(23)) begin
                    state_d = ST_PACK;
                end else if (mag_q[ACC_W-1 -: SCAN_STEP] == '0 &&
                             p_q >= PW'(23 + SCAN_STEP)) begin
                    mag_d = mag_q << SCAN_STEP;
                    p_d   = p_q - PW'(SCAN_STEP);
                end else begin
                    mag_d = mag_q << 1;
                    p_d   = p_q - PW'(1);
                end
            end
            ST_PACK: begin
                if (zero_q) begin
                    out_data_d = 32'h0;
                end else if (p_q >= PW'(24)) begin
                    if (exp_w >= PW'(255)) begin
                        out_data_d = {sgn_q, 8'hFF, 23'h0};
                    end else begin
                        out_data_d = {sgn_q, exp_w[7:0], mag_q[ACC_W-2 -: 23]};
                    end
                end else begin
                    // Stopped at p==23: mag holds |acc|[23:1] on top, which is
                    // exactly the denormal mantissa (bit 23 has weight 2^-127).
                    out_data_d = {sgn_q, 8'h00, mag_q[ACC_W-1 -: 23]};
                end
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d    = ST_ACCUM;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            mag_q       <= '0;
            p_q         <= '0;
            sgn_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mag_q       <= mag_d;
            p_q         <= p_d;
            sgn_q       <= sgn_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_large_acc_to_float.sv
// Randomised and directed bench for large_acc_to_float.
// Expected floats come from an arithmetic leading-one model of the exact batch sum.
module tb_large_acc_to_float;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [278:0] in_data_i;
    logic         in_last_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [31:0]  out_data_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [278:0] terms[$];

    large_acc_to_float dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .in_last_i  (in_last_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [299:0] sum_terms();
        logic [299:0] s = '0;
        foreach (terms[i]) s = s + {{21{terms[i][278]}}, terms[i]};
        return s;
    endfunction

    // Float32 of an exact value s * 2^-150, truncated toward zero.
    function automatic logic [31:0] ref_float(input logic [299:0] s);
        logic [299:0] m;
        logic [299:0] sh;
        logic         sg;
        int           l;
        sg = s[299];
        m  = sg ? -s : s;
        if (m == '0) return 32'h0;
        l = 0;
        for (int i = 0; i < 300; i++) if (m[i]) l = i;
        if (l <= 23) begin
            sh = m >> 1;
            return {sg, 8'h00, sh[22:0]};
        end
        if (l - 23 >= 255) return {sg, 8'hFF, 23'h0};
        sh = m >> (l - 23);
        return {sg, 8'(l - 23), sh[22:0]};
    endfunction

    function automatic logic [278:0] rand_term();
        logic [278:0] t;
        int           sh;
        if ($urandom_range(0, 3) == 0) begin
            t  = 279'($urandom_range(1, 255));
            sh = $urandom_range(0, 30);
        end else begin
            t  = 279'($urandom_range(1, 32'hFFFFFF));
            sh = $urandom_range(0, 254);
        end
        t = t << sh;
        if ($urandom_range(0, 1) == 1) t = -t;
        return t;
    endfunction

    task automatic run_batch(input int hold, output logic [31:0] got);
        int k;
        int n;
        n = terms.size();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) begin
                @(negedge clk_i);
                in_valid_i = 1'b0;
            end
            @(negedge clk_i);
            in_valid_i = 1'b1;
            in_data_i  = terms[i];
            in_last_i  = (i == n - 1);
            k = 0;
            while (!in_ready_o && k < 64) begin
                @(negedge clk_i);
                k++;
            end
            if (!in_ready_o) chk("in_ready_timeout", 32'(in_ready_o), 32'd1);
            @(posedge clk_i);
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        k = 1;
        while (!out_valid_o && k < 64) begin
            chk("busy_ready", 32'(in_ready_o), 32'd0);
            @(negedge clk_i);
            k++;
        end
        chk("out_valid_seen", 32'(out_valid_o), 32'd1);
        chk("latency_ok", 32'(k <= 46), 32'd1);
        got = out_data_o;
        repeat (hold) begin
            @(negedge clk_i);
            chk("hold_data", out_data_o, got);
            chk("hold_valid", 32'(out_valid_o), 32'd1);
            chk("hold_ready", 32'(in_ready_o), 32'd0);
        end
        out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        out_ready_i = 1'b0;
        chk("post_valid", 32'(out_valid_o), 32'd0);
        chk("post_ready", 32'(in_ready_o), 32'd1);
    endtask

    logic [278:0] one_t;
    logic [278:0] max_t;
    logic [278:0] x;
    logic [31:0]  got;
    logic [31:0]  exp;

    initial begin
        one_t = 279'(1) << 150;
        max_t = 279'(32'hFFFFFF) << 254;
        rst_n_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_data", out_data_o, 32'h0);
        rst_n_i = 1'b1;

        terms = '{one_t};
        run_batch(5, got);
        chk("one", got, 32'h3F800000);

        terms = '{one_t, -one_t};
        run_batch(0, got);
        chk("cancel_pos_zero", got, 32'h00000000);

        terms = '{279'(3) << 149, 279'(9) << 148, 279'(1)};
        run_batch(1, got);
        chk("three_75", got, 32'h40700000);

        terms = '{max_t, max_t, max_t, max_t};
        run_batch(0, got);
        chk("pos_inf", got, 32'h7F800000);

        terms = '{-max_t, -max_t, -max_t, -max_t};
        run_batch(0, got);
        chk("neg_inf", got, 32'hFF800000);

        terms = '{279'(6)};
        run_batch(0, got);
        chk("denorm_6", got, 32'h00000003);

        terms = '{-279'(6)};
        run_batch(0, got);
        chk("denorm_m6", got, 32'h80000003);

        terms = '{279'(1)};
        run_batch(0, got);
        chk("denorm_1", got, 32'h00000000);

        // Reset while the leading-one scan is in progress.
        @(negedge clk_i);
        in_valid_i = 1'b1;
        in_data_i  = 279'(1);
        in_last_i  = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("scan_busy", 32'(in_ready_o), 32'd0);
        rst_n_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("midscan_rst_valid", 32'(out_valid_o), 32'd0);
        chk("midscan_rst_ready", 32'(in_ready_o), 32'd1);
        rst_n_i = 1'b1;

        terms = '{one_t};
        run_batch(0, got);
        chk("after_rst_one", got, 32'h3F800000);

        for (int b = 0; b < 40; b++) begin
            terms = {};
            repeat ($urandom_range(1, 6)) terms.push_back(rand_term());
            if ($urandom_range(0, 3) == 0) begin
                x = rand_term();
                terms.push_back(x);
                terms.push_back(-x);
            end
            exp = ref_float(sum_terms());
            run_batch($urandom_range(0, 3), got);
            chk("rand_batch", got, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
